// File: rtl/btn_event_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : btn_event_ctrl
//  Purpose  : Multi-button input controller. Each pushbutton is synchronised,
//             debounced by counting consecutive differing samples on a shared
//             sample tick, and turned into press/release events. Events are
//             serialised onto one valid/ready channel by a round-robin arbiter.
//  Ports    : clk        - system clock, all logic on posedge
//             rst        - asynchronous active-high reset
//             btn        - raw asynchronous pushbutton inputs (active-high)
//             level      - debounced button levels
//             evt_valid  - event present on evt_id / evt_press
//             evt_id     - index of the button that produced the event
//             evt_press  - 1 = press (0->1), 0 = release (1->0)
//             evt_ready  - consumer accepts event on evt_valid & evt_ready
//             evt_lost   - one-cycle pulse when a pending event is overwritten
//  Options  : BTN_EVT_RELEASE_EN - when defined, release events are queued as
//             well as presses; otherwise only presses produce events.
//  Revision : 1.0 - initial release
// ============================================================================
module btn_event_ctrl #(
    parameter int N_BTN      = 4,
    parameter int TICK_DIV   = 50000,
    parameter int STABLE_CNT = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_BTN-1:0]         btn,
    output logic [N_BTN-1:0]         level,
    output logic                     evt_valid,
    output logic [$clog2(N_BTN)-1:0] evt_id,
    output logic                     evt_press,
    input  logic                     evt_ready,
    output logic                     evt_lost
);

    localparam int              IDW         = $clog2(N_BTN);
    localparam int              TCW         = $clog2(TICK_DIV);
    localparam logic [TCW-1:0]  C_TICK_LAST = TCW'(TICK_DIV - 1);
    localparam logic [3:0]      C_STABLE    = 4'(STABLE_CNT);
    localparam logic [IDW-1:0]  C_LAST_ID   = IDW'(N_BTN - 1);
    localparam logic [IDW:0]    C_N_WIDE    = (IDW + 1)'(N_BTN);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;
    logic [TCW-1:0]   r_tick_cnt;
    logic             w_tick;
    logic [N_BTN-1:0] r_level;
    logic [N_BTN-1:0] w_raise;
    logic [N_BTN-1:0] w_set;
    logic [N_BTN-1:0] r_pend;
    logic [N_BTN-1:0] r_pol;
    logic             r_lost;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDW-1:0]   r_rr;
    logic [IDW-1:0]   r_id;
    logic             r_press;
    logic             w_found;
    logic [IDW-1:0]   w_grant_id;
    logic [N_BTN-1:0] w_grant_vec;
    logic [IDW:0]     w_sum;

    // Two-flop synchroniser for the asynchronous button inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
        end
    end

    // Shared sample tick.
    assign w_tick = (r_tick_cnt == C_TICK_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    // Per-button consecutive-sample debounce.
    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        logic [3:0] r_cnt;
        logic [3:0] w_cnt_inc;
        logic       w_differs;

        assign w_cnt_inc  = r_cnt + 4'd1;
        assign w_differs  = (r_sync2[i] != r_level[i]);
        assign w_raise[i] = w_tick && w_differs && (w_cnt_inc == C_STABLE);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (w_tick) begin
                if (!w_differs || w_raise[i]) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= w_cnt_inc;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level <= '0;
        end else begin
            r_level <= r_level ^ w_raise;
        end
    end

`ifdef BTN_EVT_RELEASE_EN
    assign w_set = w_raise;
`else
    // Only a 0->1 flip (current level 0) queues an event.
    assign w_set = w_raise & ~r_level;
`endif

    // Pending events. A set in the same cycle as a grant of that button wins,
    // and is not counted as a loss since the granted event was already taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= '0;
            r_pol  <= '0;
            r_lost <= 1'b0;
        end else begin
            r_pend <= (r_pend & ~w_grant_vec) | w_set;
            r_pol  <= (r_pol & ~w_set) | (~r_level & w_set);
            r_lost <= |(w_set & r_pend & ~w_grant_vec);
        end
    end

    // Output FSM: round-robin search from rr, wrapping upward.
    always_comb begin
        w_state_nxt = r_state;
        w_found     = 1'b0;
        w_grant_id  = '0;
        w_grant_vec = '0;
        w_sum       = '0;
        case (r_state)
            S_IDLE: begin
                for (int k = 0; k < N_BTN; k++) begin
                    w_sum = {1'b0, r_rr} + (IDW + 1)'(k);
                    if (w_sum >= C_N_WIDE) begin
                        w_sum = w_sum - C_N_WIDE;
                    end
                    if (!w_found && r_pend[w_sum[IDW-1:0]]) begin
                        w_found    = 1'b1;
                        w_grant_id = w_sum[IDW-1:0];
                    end
                end
                if (w_found) begin
                    w_grant_vec[w_grant_id] = 1'b1;
                    w_state_nxt             = S_HOLD;
                end
            end
            S_HOLD: begin
                if (evt_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rr    <= '0;
            r_id    <= '0;
            r_press <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_found) begin
                r_id    <= w_grant_id;
                r_press <= r_pol[w_grant_id];
                r_rr    <= (w_grant_id == C_LAST_ID) ? '0 : w_grant_id + 1'b1;
            end
        end
    end

    assign level     = r_level;
    assign evt_valid = (r_state == S_HOLD);
    assign evt_id    = r_id;
    assign evt_press = r_press;
    assign evt_lost  = r_lost;

endmodule
`default_nettype wire

// File: doc/btn_event_ctrl.md
# btn_event_ctrl

Multi-button input controller that shares one sample-tick generator and one event channel among `N_BTN` pushbuttons. Each button is synchronised, debounced by consecutive-sample counting, and turned into press/release events. A round-robin arbiter serialises these events onto a single valid/ready port. It sits between the board pushbuttons and the control FSMs, replacing per-button divider and flip-flop chains.

## Interface
- `N_BTN`, 4: number of buttons, 2..16.
- `TICK_DIV`, 50000: sample period in `clk` cycles, ≥2.
- `STABLE_CNT`, 3: consecutive differing samples required to flip a level, 1..15.
- `clk` in 1: system clock; all logic rises on `posedge clk`.
- `rst` in 1: asynchronous, active-high reset.
- `btn` in `N_BTN`: raw pushbutton inputs, asynchronous, active-high.
- `level` out `N_BTN`: debounced button levels.
- `evt_valid` out 1: event present on `evt_id`/`evt_press`.
- `evt_id` out `$clog2(N_BTN)`: index of the button that produced the event.
- `evt_press` out 1: 1 = press (0→1), 0 = release (1→0).
- `evt_ready` in 1: consumer accepts the event when `evt_valid & evt_ready` is high at a clock edge.
- `evt_lost` out 1: one-cycle pulse when a pending event is overwritten.

## Operation
- Reset values: `level`=0, `evt_valid`=0, `evt_id`=0, `evt_press`=0, `evt_lost`=0. Synchroniser, tick counter, stable counters, pending bits and RR pointer are also 0. Reset takes effect asynchronously on assertion.
- Synchroniser: two flops per bit, producing `bs`.
- Tick: counter 0..`TICK_DIV`-1 that wraps; `tick` is high for one cycle when the count equals `TICK_DIV`-1.
- Per-button debounce, evaluated only on `tick`:
  - If `bs[i]` ≠ `level[i]`: `cnt[i]`++.
  - When the increment reaches `STABLE_CNT`: `level[i]` toggles, `cnt[i]`←0, and an event is raised.
  - If `bs[i]` = `level[i]`: `cnt[i]`←0.
- Pending register per button: `pend[i]` and `pol[i]`.
  - A raised event sets `pend[i]` and writes `pol[i]` with the new level.
  - If `pend[i]` is already set and not being granted that cycle, `pol[i]` is overwritten and `evt_lost` pulses.
  - If a set and a grant clear happen in the same cycle, the set wins and `evt_lost` stays 0.
- Output FSM:
  - IDLE: `evt_valid`=0. If any `pend` bit is set, grant the first set index at or after `rr` (wrapping upward). Load `evt_id` and `evt_press`←`pol`, clear that `pend` bit, set `rr`←(grant+1) mod `N_BTN`, and go to HOLD.
  - HOLD: `evt_valid`=1; `evt_id` and `evt_press` are stable. On `evt_ready`, go to IDLE.
  - No same-cycle reload, so throughput is at most one event per 2 cycles.
- `evt_ready` is ignored in IDLE.

## Timing
- Input edge to `bs` change: 2 cycles.
- `level[i]` flips on the cycle after the `STABLE_CNT`-th consecutive qualifying tick.
- `pend` is set in the same cycle as the `level` flip.
- `evt_valid` rises 1 cycle after `pend` is set, if the FSM is IDLE and this button is selected.
- `evt_valid` falls the cycle after the handshake.
- `evt_lost` is registered and is high for exactly 1 cycle per overwrite.
- Bounce shorter than `STABLE_CNT` ticks produces no `level` change and no event.
- Reset deasserted mid-HOLD: the event is discarded and no event is replayed.

## Configuration
- `BTN_EVT_RELEASE_EN` defined: both press and release events are queued.
- Undefined:
  - Only 0→1 transitions set `pend`; `evt_press` is always 1.
  - `level` still tracks releases.
  - A press arriving while a press is pending still pulses `evt_lost`.

## Test plan
Use `TICK_DIV`=4, `STABLE_CNT`=3, `N_BTN`=4 with `BTN_EVT_RELEASE_EN` defined, unless stated otherwise.
- Reset: `rst`=1 with `btn`=4'b1111 for 20 cycles → `level`=0, `evt_valid`=0, `evt_lost`=0. Release `rst` → `level` becomes 4'b1111 after 3 ticks, and events appear for ids 0,1,2,3 in order.
- Bounce: `btn[0]` toggles every 3 cycles for 24 cycles, then held at 1 → exactly one event (id 0, press=1). No event occurs during bouncing.
- Arbitration: `btn[1]` and `btn[3]` rise in the same cycle, `evt_ready`=1 → id 1 then id 3, each `evt_valid` lasting 1 cycle and separated by 1 IDLE cycle. Then `btn[0]` and `btn[3]` rise together (rr=0) → id 0 then id 3.
- Backpressure and loss: `evt_ready`=0; press then release `btn[2]` → `evt_valid` holds (2, press); the release is pending. Press `btn[2]` again → `evt_lost` pulses once. Raise `evt_ready` → the next event is (2, press=1).
- Async reset mid-operation: assert `rst` while `evt_valid`=1 → `evt_valid`, `level`, `evt_lost` are 0 before the next `clk` edge.
- Macro undefined: press then release `btn[1]` with `evt_ready`=1 → a single event (1, press=1). `level[1]` returns to 0 and no second event is produced.
